// File: rtl/mini_alu_pkg.sv
// rtl/mini_alu_pkg.sv - shared types for the mini ALU sequencer, datapath and bench
package mini_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } st_e;

  typedef enum logic [1:0] {
    OP_LDLO = 2'd0,
    OP_LDHI = 2'd1,
    OP_ADD  = 2'd2,
    OP_SUB  = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] z;
  } instr_t;

endpackage

// File: rtl/mini_alu_sequencer_if.sv
// rtl/mini_alu_sequencer_if.sv - program load port and instruction issue port
interface mini_alu_sequencer_if #(
  parameter int DEPTH = 16
) ();
  localparam int PC_W = $clog2(DEPTH);

  logic            load_we;
  logic [PC_W-1:0] load_addr;
  logic [7:0]      load_data;
  logic [7:0]      instr;
  logic            exec_en;

  // host side: writes the program, watches issued instructions
  modport master (
    output load_we, load_addr, load_data,
    input  instr, exec_en
  );

  // sequencer side
  modport slave (
    input  load_we, load_addr, load_data,
    output instr, exec_en
  );
endinterface

// File: rtl/mini_alu_prog_mem.sv
// rtl/mini_alu_prog_mem.sv - DEPTH x 8 instruction store, sync write, async read
module mini_alu_prog_mem #(
  parameter int DEPTH = 16,
  localparam int PC_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [7:0]      rdata
);
  logic [7:0] mem [DEPTH];

  // write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mini_alu_sequencer.sv
// rtl/mini_alu_sequencer.sv - run/step/halt program sequencer for the mini ALU
import mini_alu_pkg::*;

module mini_alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int RATE  = 12_000_000,
  localparam int PC_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  input  logic [PC_W:0]     prog_len,
  output logic [PC_W-1:0]   pc,
  output logic [1:0]        state,
  output logic              done,
  mini_alu_sequencer_if.slave bus
);
  localparam int CNT_W = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RATE - 1);
  localparam logic [PC_W:0]    DEPTH_LEN = (PC_W + 1)'(DEPTH);

  st_e              st_q, st_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  instr_t           instr_q, instr_d;
  logic             exec_q, exec_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, step_q;
  logic             issue;
  logic             mem_we;
  logic [7:0]       rd_data;
  logic [PC_W:0]    eff_len;
  logic [PC_W:0]    pc_inc;
  logic             start_rise, step_rise;

  assign start_rise = start & ~start_q;
  assign step_rise  = step & ~step_q;
  // 0 and anything beyond the memory both mean "run the whole memory"
  assign eff_len    = (prog_len == '0 || prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign pc_inc     = {1'b0, pc_q} + (PC_W + 1)'(1);
  // the program may only change while nothing is being issued
  assign mem_we     = bus.load_we && (st_q == IDLE || st_q == HALT);

  mini_alu_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  // next-state: abort wins, then start edge, then step edge, then the rate counter
  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    exec_d  = 1'b0;
    done_d  = done_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    if (abort) begin
      st_d   = IDLE;
      pc_d   = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (start_rise) begin
            st_d  = RUN;
            pc_d  = '0;
            cnt_d = '0;
          end else if (step_rise) begin
            st_d  = STEP;
            issue = 1'b1;
          end
        end
        RUN: begin
          if (start_rise) begin
            pc_d  = '0;
            cnt_d = '0;
          end else if (step_rise) begin
            st_d = STEP;
          end else if (cnt_q == CNT_LAST) begin
            issue = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STEP: begin
          if (start_rise) begin
            st_d  = RUN;
            cnt_d = '0;
          end else if (step_rise) begin
            issue = 1'b1;
          end
        end
        HALT: begin
          if (start_rise) begin
            st_d   = RUN;
            pc_d   = '0;
            cnt_d  = '0;
            done_d = 1'b0;
          end
        end
        default: st_d = IDLE;
      endcase
    end
    if (issue) begin
      instr_d = instr_t'(rd_data);
      exec_d  = 1'b1;
      if (pc_inc == eff_len) begin
        pc_d   = '0;
        st_d   = HALT;
        done_d = 1'b1;
      end else begin
        pc_d = pc_inc[PC_W-1:0];
      end
    end
  end

  // state register; edge-detect history resets high so a held button is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      pc_q    <= '0;
      instr_q <= instr_t'(8'h00);
      exec_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exec_q  <= exec_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      start_q <= start;
      step_q  <= step;
    end
  end

  assign pc          = pc_q;
  assign state       = st_q;
  assign done        = done_q;
  assign bus.instr   = instr_q;
  assign bus.exec_en = exec_q;
endmodule
